// File: rtl/dcache_controller_if.sv
// Line-transfer bus between the L1 data cache
// and the data memory model.
interface dcache_controller_if #(
  parameter int LINE_W = 256
);
  logic              enable;
  logic              write;
  logic [31:0]       addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ack;

  modport master (
    output enable, write, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  enable, write, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate L1 data
// cache; misses stall the MEM stage during line moves.
module dcache_controller #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p1_MemRead_i,
  input  logic        p1_MemWrite_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_data_i,
  output logic [31:0] p1_data_o,
  output logic        p1_stall_o,
  dcache_controller_if.master mem
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RM,
    S_RD
  } state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [WSEL_W+4:0] wbit;
  logic [LINE_W-1:0] cur_line;
  logic [LINE_W-1:0] line_d;
  logic              req;
  logic              hit;
  logic              fill;
  logic              wr_hit;
  logic              line_we;
  logic              unused_addr_lsb;

  assign idx  = p1_addr_i[OFF_W +: IDX_W];
  assign tag  = p1_addr_i[31 -: TAG_W];
  assign wsel = p1_addr_i[OFF_W-1:2];
  assign wbit = {wsel, 5'b0};

  assign unused_addr_lsb = ^p1_addr_i[1:0];

  assign cur_line = data_q[idx];
  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign hit      = valid_q[idx]
                  && (tag_q[idx] == tag);

  assign p1_data_o = cur_line[wbit +: 32];
  assign mem.wdata = cur_line;

  // Writes on a hit only happen from IDLE, so the
  // refilled line is updated on the retried access.
  assign fill    = (state_q == S_RM) && mem.ack;
  assign wr_hit  = (state_q == S_IDLE)
                 && p1_MemWrite_i && hit;
  assign line_we = fill | wr_hit;

  always_comb begin
    state_d    = state_q;
    p1_stall_o = 1'b0;
    mem.enable = 1'b0;
    mem.write  = 1'b0;
    mem.addr   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          p1_stall_o = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d = S_WB;
          end else begin
            state_d = S_RM;
          end
        end
      end
      S_WB: begin
        p1_stall_o = 1'b1;
        mem.enable = 1'b1;
        mem.write  = 1'b1;
        mem.addr   = {tag_q[idx], idx,
                      {OFF_W{1'b0}}};
        if (mem.ack) begin
          state_d = S_RM;
        end
      end
      S_RM: begin
        p1_stall_o = 1'b1;
        mem.enable = 1'b1;
        mem.addr   = {tag, idx, {OFF_W{1'b0}}};
        if (mem.ack) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        p1_stall_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    line_d  = cur_line;
    unique case (1'b1)
      fill: begin
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        line_d       = mem.rdata;
      end
      wr_hit: begin
        dirty_d[idx]        = 1'b1;
        line_d[wbit +: 32]  = p1_data_i;
      end
      default: begin
        line_d = cur_line;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; valid
  // bits alone decide whether contents matter.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      data_q[idx] <= line_d;
    end
    if (fill) begin
      tag_q[idx] <= tag;
    end
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

L1 data cache controller that services the load/store requests raised by the main decoder's `MemRead`/`MemWrite` controls in the MEM stage. It is a direct-mapped, write-back, write-allocate cache: hits complete with zero wait, and misses freeze the pipeline through `p1_stall_o` while lines are exchanged with data memory over an enable/ack handshake. It sits between the EX/MEM pipeline register and the data memory model.

## Interface
- `NUM_LINES`, 32, cache lines; index width is log2(`NUM_LINES`) = 5.
- `LINE_W`, 256, bits per line (32 bytes, 8 words).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `p1_MemRead_i`  in  1  load request from MEM stage.
- `p1_MemWrite_i`  in  1  store request from MEM stage.
- `p1_addr_i`  in  32  byte address; tag [31:10], index [9:5], word [4:2]; [1:0] ignored.
- `p1_data_i`  in  32  store data.
- `p1_data_o`  out  32  load data; valid when a read is active and `p1_stall_o`=0.
- `p1_stall_o`  out  1  freeze pipeline.
- `mem_enable_o`  out  1  memory request valid.
- `mem_write_o`  out  1  1 = line write-back, 0 = line fill.
- `mem_addr_o`  out  32  line-aligned address; [4:0] = 0.
- `mem_data_o`  out  256  write-back line data.
- `mem_data_i`  in  256  fill line data; sampled with `mem_ack_i`.
- `mem_ack_i`  in  1  single-cycle completion pulse.

## Operation
- Per-line storage: valid bit, dirty bit, 22-bit tag, 256-bit data.
- Hit = valid[index] && tag[index] == `p1_addr_i`[31:10].
- Request = `p1_MemRead_i` || `p1_MemWrite_i`. If both are asserted, the request is treated as a write with no read data.
- FSM states: IDLE, WRITEBACK, READMISS, REFILLDONE.
- IDLE, read hit: `p1_data_o` is the selected word, combinationally, with no stall.
- IDLE, write hit: the selected word is replaced at the clock edge and dirty is set; no stall.
- IDLE, miss: stall is asserted in the same cycle. Next state is WRITEBACK if the victim is valid and dirty, otherwise READMISS.
- WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1.
  - `mem_addr_o` = {victim tag, index, 5'b0}; `mem_data_o` = victim line.
  - On `mem_ack_i`, go to READMISS.
- READMISS: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o` = {req tag, index, 5'b0}.
  - On `mem_ack_i`, the line is loaded from `mem_data_i`, valid is set, dirty is cleared, the tag is written, and the FSM goes to REFILLDONE.
- REFILLDONE: stall held for one cycle, then IDLE. The still-held request now hits and completes through the IDLE hit path; a write sets dirty there.
- `p1_stall_o` = (state != IDLE) || (IDLE && request && !hit).
- The pipeline holds the request fields stable while stall = 1. The controller does not latch them.
- `mem_ack_i` is ignored in IDLE and REFILLDONE.
- With no request, the FSM stays in IDLE, `p1_stall_o`=0, and `mem_enable_o`=0.

## Timing
- Reset (asynchronous assert):
  - state = IDLE; all valid and dirty bits = 0; `mem_enable_o`=0 and `mem_write_o`=0 immediately.
  - `p1_stall_o` = 1 only if a request is present, since every access misses after reset.
  - Data and tag arrays are not reset.
- Reset deassertion takes effect at the next rising edge.
- Reset mid-transaction abandons the transfer: no fill occurs, and a pending dirty line is lost. This is the required behaviour.
- `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are registered or state-decoded. They are stable for the whole request until the ack cycle and drop the cycle after the ack.
- Clean miss, request first seen at edge 0 with ack in cycle k (k ≥ 1):
  - READMISS runs for cycles 1..k.
  - REFILLDONE is cycle k+1.
  - The hit completes in cycle k+2 with `p1_stall_o`=0.
- Dirty miss: WRITEBACK ack at cycle j, then READMISS from cycle j+1 to its ack, then as above.
- Memory latency has no upper bound; the controller waits indefinitely.

## Test plan
- Reset, then read 0x0000_0040 with memory returning a line whose word 0 is 0x1111_1111 and ack at latency 4:
  - one READMISS request to 0x0000_0040;
  - stall for 6 cycles;
  - `p1_data_o`=0x1111_1111 in the completing cycle.
- Write 0xDEAD_BEEF to 0x0000_0044 right after the fill above, then read it back:
  - no stall on either access;
  - the read returns 0xDEAD_BEEF;
  - no memory traffic.
- Read 0x0000_0440 (same index 2, different tag) while line 2 is dirty:
  - WRITEBACK to 0x0000_0040 with word 1 = 0xDEAD_BEEF in `mem_data_o`;
  - then READMISS to 0x0000_0440.
- Read 0x0000_0840 while line 2 is clean:
  - no WRITEBACK, READMISS only.
- Assert reset while in READMISS before the ack:
  - `mem_enable_o` drops asynchronously;
  - a later read of the same address misses again.
- Assert `p1_MemRead_i` and `p1_MemWrite_i` together on a hit to 0x0000_0044 with data 0x5:
  - handled as a write;
  - a later read returns 0x5.
